// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT MAC engine: FSM states, loop sizes,
// the cosine coefficient generator and the output round/saturate helper.
package dct_pkg;

    localparam int N_POINTS     = 8;
    localparam int FETCH_CYCLES = 8;
    localparam int MAC_CYCLES   = 64;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        MAC,
        DONE
    } state_t;

    // cos(j*pi/16) scaled by 2^24 for j = 0..8
    function automatic longint cos_base_q24(input int j);
        case (j)
            0:       return 64'sd16777216;
            1:       return 64'sd16454846;
            2:       return 64'sd15500126;
            3:       return 64'sd13949745;
            4:       return 64'sd11863283;
            5:       return 64'sd9320923;
            6:       return 64'sd6420363;
            7:       return 64'sd3273072;
            default: return 64'sd0;
        endcase
    endfunction

    // round(2^frac * s(k) * cos((2n+1)k*pi/16)); s(0) = cos(pi/4)/2, s(k>0) = 1/2
    function automatic int dct_coef(input int k, input int n, input int frac);
        int     m;
        longint v;
        m = ((2 * n + 1) * k) % 32;
        if (m <= 8)
            v = cos_base_q24(m);
        else if (m <= 16)
            v = -cos_base_q24(16 - m);
        else if (m <= 24)
            v = -cos_base_q24(m - 16);
        else
            v = cos_base_q24(32 - m);
        if (k == 0)
            v = cos_base_q24(4);
        return int'(((v <<< frac) + (longint'(1) <<< 24)) >>> 25);
    endfunction

    function automatic longint round_sat(input longint acc, input int frac, input int out_w);
        longint r;
        longint hi;
        longint lo;
        r  = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -(longint'(1) <<< (out_w - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/dct_8_mac_engine_if.sv
// Sample-memory read port and coefficient write port of the DCT engine.
interface dct_8_mac_engine_if #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 12,
    parameter int ADDR_WIDTH = 9
);
    logic                        fetch_en;
    logic [ADDR_WIDTH-1:0]       fetch_addr;
    logic [IN_WIDTH-1:0]         fetch_data;
    logic                        result_wr;
    logic [2:0]                  result_addr;
    logic signed [OUT_WIDTH-1:0] result_data;

    modport master (
        output fetch_en, fetch_addr, result_wr, result_addr, result_data,
        input  fetch_data
    );

    modport slave (
        input  fetch_en, fetch_addr, result_wr, result_addr, result_data,
        output fetch_data
    );
endinterface

// File: rtl/dct_coef_rom.sv
// 64-entry cosine coefficient lookup indexed by {k, n}, built at elaboration.
module dct_coef_rom #(
    parameter int COEF_FRAC = 12
) (
    input  logic [5:0]                idx,
    output logic signed [COEF_FRAC+1:0] coef
);
    import dct_pkg::*;

    logic signed [COEF_FRAC+1:0] rom_q [64];

    for (genvar i = 0; i < 64; i++) begin : g_rom
        assign rom_q[i] = (COEF_FRAC+2)'(dct_coef(i / 8, i % 8, COEF_FRAC));
    end

    assign coef = rom_q[idx];
endmodule

// File: rtl/dct_8_mac_engine.sv
// Strided 8-sample fetch, optional level shift, sequential MAC 1-D DCT-II and
// rounded/saturated coefficient write-back.
module dct_8_mac_engine #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int COEF_FRAC  = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic                  level_shift,
    output logic                  busy,
    output logic                  done,
    dct_8_mac_engine_if.master    bus
);
    import dct_pkg::*;

    localparam int ACC_WIDTH = IN_WIDTH + COEF_FRAC + 5;
    localparam int X_WIDTH   = IN_WIDTH + 1;

    state_t                      state;
    state_t                      next_state;
    logic [5:0]                  cnt;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [ADDR_WIDTH-1:0]       stride_q;
    logic                        level_shift_q;
    logic                        cap_en;
    logic [2:0]                  cap_idx;
    logic signed [X_WIDTH-1:0]   x [N_POINTS];
    logic signed [X_WIDTH-1:0]   x_in;
    logic signed [COEF_FRAC+1:0] coef;
    logic signed [ACC_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        row_end;

    // In MAC the counter is {k, n}, which is exactly the ROM index
    dct_coef_rom #(.COEF_FRAC(COEF_FRAC)) u_rom (
        .idx  (cnt),
        .coef (coef)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (cnt == 6'(FETCH_CYCLES - 1)) next_state = FILL;
            FILL:    next_state = MAC;
            MAC:     if (cnt == 6'(MAC_CYCLES - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign bus.fetch_en   = (state == FETCH);
    assign bus.fetch_addr = addr;

    // Subtracting 2^(IN_WIDTH-1) from an unsigned sample just inverts its MSB
    assign x_in = level_shift_q
                ? {~bus.fetch_data[IN_WIDTH-1], ~bus.fetch_data[IN_WIDTH-1], bus.fetch_data[IN_WIDTH-2:0]}
                : {bus.fetch_data[IN_WIDTH-1], bus.fetch_data};

    assign prod     = ACC_WIDTH'(x[cnt[2:0]]) * ACC_WIDTH'(coef);
    assign acc_next = (cnt[2:0] == 3'd0) ? prod : acc + prod;
    assign row_end  = (state == MAC) && (cnt[2:0] == 3'd7);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt             <= '0;
            addr            <= '0;
            stride_q        <= '0;
            level_shift_q   <= 1'b0;
            cap_en          <= 1'b0;
            cap_idx         <= '0;
            acc             <= '0;
            bus.result_wr   <= 1'b0;
            bus.result_addr <= '0;
            bus.result_data <= '0;
            for (int i = 0; i < N_POINTS; i++)
                x[i] <= '0;
        end else begin
            cnt     <= (next_state != state) ? 6'd0 : cnt + 6'd1;
            cap_en  <= (state == FETCH);
            cap_idx <= cnt[2:0];
            if (state == IDLE && start) begin
                addr          <= base_addr;
                stride_q      <= stride;
                level_shift_q <= level_shift;
            end else if (state == FETCH) begin
                addr <= addr + stride_q;
            end
            // Read data trails its fetch by one cycle, so sample 7 lands in FILL
            if (cap_en)
                x[cap_idx] <= x_in;
            if (state == MAC)
                acc <= acc_next;
            bus.result_wr <= row_end;
            if (row_end) begin
                bus.result_addr <= cnt[5:3];
                bus.result_data <= OUT_WIDTH'(round_sat(longint'(acc_next), COEF_FRAC, OUT_WIDTH));
            end
        end
    end
endmodule

// File: tb/tb_dct_8_mac_engine.sv
// Directed bench for dct_8_mac_engine: a 12-bit-output instance for function,
// stride, handshake and reset, plus an 8-bit-output instance for saturation.
module tb_dct_8_mac_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_s = 1'b0;
    logic [8:0] base_addr = '0;
    logic [8:0] stride = '0;
    logic       level_shift = 1'b0;
    logic       busy;
    logic       done;
    logic       busy_s;
    logic       done_s;

    logic [7:0] mem [512];

    int total = 0;
    int bad = 0;

    int wr_cnt;
    int done_cnt;
    int done_rel;
    int fetch_cnt;
    int first_fetch_rel;
    int last_wr_rel;
    int wr_rel [8];
    int wr_val [8];
    int wr_order [8];
    int fa [8];
    int busy_at [0:90];
    int exp_vals [8];

    dct_8_mac_engine_if #(.IN_WIDTH(8), .OUT_WIDTH(12), .ADDR_WIDTH(9)) bus ();
    dct_8_mac_engine_if #(.IN_WIDTH(8), .OUT_WIDTH(8),  .ADDR_WIDTH(9)) bus_s ();

    dct_8_mac_engine #(.IN_WIDTH(8), .OUT_WIDTH(12), .ADDR_WIDTH(9), .COEF_FRAC(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .stride      (stride),
        .level_shift (level_shift),
        .busy        (busy),
        .done        (done),
        .bus         (bus.master)
    );

    dct_8_mac_engine #(.IN_WIDTH(8), .OUT_WIDTH(8), .ADDR_WIDTH(9), .COEF_FRAC(12)) dut_s (
        .clock       (clock),
        .reset       (reset),
        .start       (start_s),
        .base_addr   (base_addr),
        .stride      (stride),
        .level_shift (level_shift),
        .busy        (busy_s),
        .done        (done_s),
        .bus         (bus_s.master)
    );

    always #5 clock = ~clock;

    // Registered-read sample memory shared by both engines
    always @(posedge clock) begin
        if (bus.fetch_en)
            bus.fetch_data <= mem[bus.fetch_addr];
        if (bus_s.fetch_en)
            bus_s.fetch_data <= mem[bus_s.fetch_addr];
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] got, input logic signed [63:0] expected);
        total++;
        if (got !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
        end
    endtask

    // Issue a start at cycle T, then record every cycle T+rel at the falling edge
    task automatic applyStimulus(input bit sat, input int b, input int s, input logic ls,
                                 input int restart_at, input int reset_at, input int n_cycles);
        logic wr_o;
        logic done_o;
        logic fe_o;
        logic busy_o;
        int   addr_o;
        int   data_o;
        int   ka;
        @(negedge clock);
        base_addr   = 9'(b);
        stride      = 9'(s);
        level_shift = ls;
        start       = !sat;
        start_s     = sat;
        wr_cnt = 0; done_cnt = 0; done_rel = -1; fetch_cnt = 0; first_fetch_rel = -1; last_wr_rel = -1;
        for (int i = 0; i < 8; i++) begin
            wr_rel[i] = -1; wr_val[i] = -9999; wr_order[i] = -1; fa[i] = -1;
        end
        for (int rel = 1; rel <= n_cycles; rel++) begin
            @(negedge clock);
            wr_o   = sat ? bus_s.result_wr : bus.result_wr;
            done_o = sat ? done_s : done;
            fe_o   = sat ? bus_s.fetch_en : bus.fetch_en;
            busy_o = sat ? busy_s : busy;
            addr_o = sat ? int'(bus_s.fetch_addr) : int'(bus.fetch_addr);
            data_o = sat ? int'(bus_s.result_data) : int'(bus.result_data);
            ka     = sat ? int'(bus_s.result_addr) : int'(bus.result_addr);
            if (fe_o === 1'b1) begin
                if (fetch_cnt < 8) fa[fetch_cnt] = addr_o;
                if (fetch_cnt == 0) first_fetch_rel = rel;
                fetch_cnt++;
            end
            if (wr_o === 1'b1) begin
                if (wr_cnt < 8) wr_order[wr_cnt] = ka;
                wr_rel[ka] = rel;
                wr_val[ka] = data_o;
                wr_cnt++;
                last_wr_rel = rel;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_rel = rel;
            end
            if (rel <= 90) busy_at[rel] = (busy_o === 1'b1) ? 1 : 0;
            start   = !sat && (rel == restart_at);
            start_s = sat && (rel == restart_at);
            reset   = (rel == reset_at);
        end
    endtask

    task automatic checkResults(input string name);
        checkOutput({name, " writes"}, wr_cnt, 8);
        checkOutput({name, " done count"}, done_cnt, 1);
        checkOutput({name, " done cycle"}, done_rel, 74);
        checkOutput({name, " busy first"}, busy_at[1], 1);
        checkOutput({name, " busy last"}, busy_at[74], 1);
        checkOutput({name, " busy fall"}, busy_at[75], 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s order %0d", name, k), wr_order[k], k);
            checkOutput($sformatf("%s cycle X%0d", name, k), wr_rel[k], 18 + 8 * k);
            checkOutput($sformatf("%s X%0d", name, k), wr_val[k], exp_vals[k]);
        end
    endtask

    task automatic checkFetch(input string name, input int b, input int s);
        checkOutput({name, " fetch count"}, fetch_cnt, 8);
        checkOutput({name, " fetch start"}, first_fetch_rel, 1);
        for (int n = 0; n < 8; n++)
            checkOutput($sformatf("%s addr %0d", name, n), fa[n], (b + n * s) % 512);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset fetch_en", bus.fetch_en, 0);
        checkOutput("reset fetch_addr", bus.fetch_addr, 0);
        checkOutput("reset result_wr", bus.result_wr, 0);
        checkOutput("reset result_addr", bus.result_addr, 0);
        checkOutput("reset result_data", bus.result_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        exp_vals = '{13, -6, 0, -1, 0, 0, 0, 0};
        applyStimulus(1'b0, 0, 1, 1'b0, 0, 0, 80);
        checkResults("ramp");
        checkFetch("ramp", 0, 1);

        applyStimulus(1'b0, 0, 1, 1'b0, 5, 0, 80);
        checkResults("restart");
        checkOutput("restart fetch count", fetch_cnt, 8);

        applyStimulus(1'b0, 0, 1, 1'b0, 0, 40, 44);
        checkOutput("abort writes", wr_cnt, 3);
        checkOutput("abort last write", last_wr_rel, 34);
        checkOutput("abort done", done_cnt, 0);
        checkOutput("abort busy", busy_at[41], 0);
        applyStimulus(1'b0, 0, 1, 1'b0, 0, 0, 80);
        checkResults("post-reset");

        for (int i = 0; i < 512; i++) mem[i] = 8'd128;
        exp_vals = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 3, 8, 1'b1, 0, 0, 80);
        checkResults("shift128");
        checkFetch("stride3", 3, 8);
        checkOutput("stride3 last addr", fa[7], 59);

        for (int i = 0; i < 512; i++) mem[i] = 8'd255;
        exp_vals = '{359, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b0, 500, 8, 1'b1, 0, 0, 80);
        checkResults("shift255");
        checkFetch("wrap", 500, 8);
        checkOutput("wrap addr 1", fa[1], 508);
        checkOutput("wrap addr 2", fa[2], 4);

        for (int i = 0; i < 512; i++) mem[i] = 8'd127;
        exp_vals = '{127, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b1, 0, 1, 1'b0, 0, 0, 80);
        checkResults("sat pos");

        for (int i = 0; i < 512; i++) mem[i] = 8'h80;
        exp_vals = '{-128, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(1'b1, 0, 1, 1'b0, 0, 0, 80);
        checkResults("sat neg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_8_mac_engine.md
Name: dct_8_mac_engine

Overview:
- Parametrised successor to the fixed 8-bit, microcoded 8-point DCT.
- Fetches 8 samples from an external synchronous-read memory at a programmable base address and stride, so one engine serves both row and column passes of a 2-D 8x8 DCT.
- Optionally level-shifts unsigned pixels, computes the orthonormal 1-D DCT-II by sequential multiply-accumulate, and writes 8 rounded, saturated coefficients to a result write port.
- Sits between the block-buffer EBRs and the quantiser in the JPEG path.

Parameters:
- IN_WIDTH, 8: sample width.
- OUT_WIDTH, 12: result width (signed).
- ADDR_WIDTH, 9: fetch address width.
- COEF_FRAC, 12: fraction bits of the cosine coefficients.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of sample 0; captured on accepted start.
- stride  in  ADDR_WIDTH  address increment between samples; captured on accepted start.
- level_shift  in  1  1: samples unsigned, subtract 2^(IN_WIDTH-1); 0: samples signed. Captured on accepted start.
- fetch_en  out  1  read enable to sample memory.
- fetch_addr  out  ADDR_WIDTH  read address.
- fetch_data  in  IN_WIDTH  read data; valid the cycle after fetch_en (EBR registered read).
- result_wr  out  1  write strobe for one coefficient.
- result_addr  out  3  coefficient index k.
- result_data  out  OUT_WIDTH  coefficient X[k].
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse with the final write.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; captured registers cleared.
- Reset mid-operation: abort within the same edge. No further fetch_en or result_wr is issued, and no done pulse.
- FSM states: IDLE -> FETCH (8 cycles) -> FILL (1 cycle) -> MAC (64 cycles) -> DONE (1 cycle) -> IDLE.
- Start accepted in cycle T (IDLE, start=1). start while busy is ignored and not queued.
- FETCH, cycles T+1..T+8:
  - fetch_en=1; fetch_addr = base_addr + n*stride for n=0..7, modulo 2^ADDR_WIDTH (wrap is legal).
  - Sample n is captured into local register x[n] at cycle T+2+n. Sample 7 is captured in FILL.
  - Level shift is applied at capture. Stored samples are IN_WIDTH+1 bits signed.
- MAC, cycles T+10..T+73:
  - Outer loop k=0..7, inner loop n=0..7.
  - Product term: x[n]*C[k][n], where C[k][n] = round(2^COEF_FRAC * s(k) * cos((2n+1)k*pi/16)).
  - s(0) = 1/(2*sqrt2); s(k>0) = 1/2.
  - On n==0 the accumulator loads the product; otherwise it adds the product.
  - Accumulator width: IN_WIDTH+COEF_FRAC+5 bits, so no overflow is possible.
- Result for row k:
  - result_wr=1 at cycle T+18+8k, with result_addr=k.
  - result_data = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
  - Saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The write for row k overlaps with the first MAC of row k+1.
- Final write (k=7) is at T+74, in DONE. done=1 in the same cycle; busy falls at T+75.
- Total latency from start to done: 74 cycles. A new start is accepted in IDLE at T+75 at the earliest.
- fetch_en=0 and result_wr=0 outside their windows. result_data holds its last value when result_wr=0.

Decomposition:
- Package dct_pkg:
  - Coefficient-table generator function (integer C[k][n] for given COEF_FRAC).
  - FSM state enum.
  - Localparams N_POINTS=8, FETCH_CYCLES, MAC_CYCLES.
  - Saturate/round helper function.
- Sub-module dct_coef_rom (combinational 64-entry lookup indexed by {k,n}, width COEF_FRAC+2 signed). The engine keeps FSM, sample registers, MAC and write logic.

Test Plan:
- Ramp: mem[0..7]=1..8, base=0, stride=1, level_shift=0.
  - Writes k=0..7 in order at T+18..T+74 step 8.
  - Values: 13, -6, 0, -1, 0, 0, 0, 0.
  - done at T+74.
- Level shift: all 8 samples = 128, level_shift=1 -> all 8 results 0. Repeat with all samples 255 -> X0 = round(127*8/(2*sqrt2)) = 359, others 0.
- Column stride with wrap:
  - Case 1: base=3, stride=8 -> fetch_addr sequence 3, 11, 19, ..., 59 on T+1..T+8.
  - Case 2: base=500, stride=8 -> addresses wrap modulo 512: 500, 508, 4, 12, ...
- Saturation: OUT_WIDTH=8, level_shift=0, all samples = 127 -> result_data[0] = 127 (saturated from 359), others 0. All samples = -128 -> X0 = -128.
- Handshake/reset:
  - start asserted again at T+5 -> ignored; exactly 8 writes and one done.
  - reset at T+40 -> no writes after T+40 and no done.
  - start at T+45 -> a clean, correct run.
